eq_band_mixer: RTL and testbench

Downstream stage of the per-band scalers. It takes the NUM_BANDS saturated, pot-scaled band samples for one audio frame and sums them serially with one adder. It saturates the sum to 16 bits, applies a master-volume gain in the same 13-bit signed Q2.10 format the band scalers use, and presents one 16-bit sample with a single-cycle valid to the DAC/codec interface.

---
 rtl/eq_band_mixer.sv | 71 +++++++
 tb/tb_eq_band_mixer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: serially sums NUM_BANDS band samples, saturates, applies Q2.10 master volume; ports clk/rst_n, in_vld+bands_in+vol_in in, aud_out+out_vld out, busy/ovr status
module eq_band_mixer #(
  parameter int NUM_BANDS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic [16*NUM_BANDS-1:0] bands_in,
  input  logic [12:0]             vol_in,
  output logic [15:0]             aud_out,
  output logic                    out_vld,
  output logic                    busy,
  output logic                    ovr
);
  localparam int IW = $clog2(NUM_BANDS);
  localparam int AW = 16 + IW;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
  state_t state, state_nx;
  logic [16*NUM_BANDS-1:0] bands_q;
  logic signed [12:0] vol_q;
  logic signed [AW-1:0] acc;
  logic [IW-1:0] idx;
  logic [15:0] band;
  logic last;
  logic signed [15:0] sum_sat;
  logic signed [28:0] prod;
  logic [15:0] res;
  always_comb begin
    band = bands_q[{idx, 4'b0000} +: 16];
    last = idx == IW'(NUM_BANDS - 1);
    sum_sat = (!acc[AW-1] && |acc[AW-2:15]) ? 16'sh7fff :
              (acc[AW-1] && !(&acc[AW-2:15])) ? 16'sh8000 : acc[15:0];
    prod = $signed({{13{sum_sat[15]}}, sum_sat}) * $signed({{16{vol_q[12]}}, vol_q});
    res = (!prod[28] && |prod[27:25]) ? 16'h7fff :
          (prod[28] && !(&prod[27:25])) ? 16'h8000 : prod[25:10];
    state_nx = state == IDLE  ? (in_vld ? ACCUM : IDLE) :
               state == ACCUM ? (last ? SCALE : ACCUM) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bands_q <= '0;
      vol_q   <= '0;
      acc     <= '0;
      idx     <= '0;
      aud_out <= '0;
      out_vld <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      ovr     <= in_vld && busy;
      if (state == IDLE && in_vld) begin
        bands_q <= bands_in;
        vol_q   <= vol_in;
        acc     <= '0;
        idx     <= '0;
      end
      if (state == ACCUM) begin
        acc <= acc + {{IW{band[15]}}, band};
        idx <= idx + IW'(1);
      end
      if (state == SCALE) begin
        aud_out <= res;
        out_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed frames checked against a cycle-level arithmetic model plus literal expectations
module tb_eq_band_mixer;
  localparam int N = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0;
  logic [16*N-1:0] bands_in = '0;
  logic [12:0] vol_in = '0;
  logic [15:0] aud_out;
  logic out_vld, busy, ovr;
  int checks = 0;
  int errors = 0;

  eq_band_mixer #(.NUM_BANDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .bands_in(bands_in), .vol_in(vol_in),
    .aud_out(aud_out), .out_vld(out_vld), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [16*N-1:0] rep(input logic [15:0] x);
    return {N{x}};
  endfunction

  function automatic logic [15:0] mix(input logic [16*N-1:0] b, input logic [12:0] v);
    longint s, p;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(b[16*i +: 16]));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    p = (s * longint'($signed(v))) >>> 10;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  int e = 0;
  int out_edge = 0;
  int start = 0;
  bit active = 0;
  bit idle;
  logic [15:0] pend = '0;
  logic [15:0] m_aud = '0;
  bit m_vld = 0, m_busy = 0, m_ovr = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      active = 0; m_aud = '0; m_vld = 0; m_busy = 0; m_ovr = 0;
    end
    chk("aud_out", aud_out, m_aud);
    chk("out_vld", out_vld, m_vld);
    chk("busy", busy, m_busy);
    chk("ovr", ovr, m_ovr);
    e++;
    if (rst_n) begin
      idle = !active || e > out_edge;
      m_vld = active && e == out_edge;
      if (m_vld) m_aud = pend;
      m_ovr = 0;
      if (in_vld) begin
        if (idle) begin
          active = 1; start = e; out_edge = e + N + 1; pend = mix(bands_in, vol_in);
        end else m_ovr = 1;
      end
      m_busy = active && e >= start && e < out_edge;
    end
  end

  task automatic drive(input logic [16*N-1:0] b, input logic [12:0] v);
    @(posedge clk); #1;
    in_vld = 1'b1; bands_in = b; vol_in = v;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [15:0] exp);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_vld) break;
      n++;
    end
    if (n == 20) chk({name, "_timeout"}, 0, 1);
    else chk(name, aud_out, exp);
  endtask

  initial begin
    chk("model_unity", mix(rep(16'h1000), 13'h0400), 16'h5000);
    chk("model_mixed", mix({16'h0001, 16'h8000, 16'h8000, 16'h7fff, 16'h7fff}, 13'h0400), 16'hffff);
    chk("model_vol_sat", mix(rep(16'h1000), 13'h0fff), 16'h7fff);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    drive(rep(16'h1000), 13'h0400);
    wait_out("unity", 16'h5000);
    drive(rep(16'h7fff), 13'h0400);
    wait_out("sum_sat_pos", 16'h7fff);
    drive(rep(16'h8000), 13'h0400);
    wait_out("sum_sat_neg", 16'h8000);
    drive({16'h0001, 16'h8000, 16'h8000, 16'h7fff, 16'h7fff}, 13'h0400);
    wait_out("no_inter_clip", 16'hffff);
    drive(rep(16'h1000), 13'h0200);
    wait_out("half_vol", 16'h2800);
    drive(rep(16'h1000), 13'h0fff);
    wait_out("prod_sat", 16'h7fff);
    drive(rep(16'h0100), 13'h0400);
    @(posedge clk);
    drive(rep(16'h7fff), 13'h0400);
    wait_out("overrun_first", 16'h0500);
    repeat (3) @(posedge clk);
    drive(rep(16'h1000), 13'h0400);
    repeat (5) @(posedge clk);
    @(posedge clk); #1;
    chk("b2b_first_vld", out_vld, 1'b1);
    chk("b2b_first", aud_out, 16'h5000);
    in_vld = 1'b1; bands_in = rep(16'h0800); vol_in = 13'h0400;
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_out("b2b_second", 16'h2800);
    drive(rep(16'h0200), 13'h0400);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bands_in = {$urandom, $urandom, $urandom};
      vol_in = 13'($urandom);
    end
    wait_out("capture_iso", 16'h0a00);
    drive(rep(16'h1000), 13'h0400);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_aud", aud_out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    drive(rep(16'h0800), 13'h0400);
    wait_out("after_rst", 16'h2800);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
